// File: rtl/oc8051_su_gate_pkg.sv
// Shared definitions for the supervisor-mode gate: fault codes, FSM states,
// frame-stack operations and default gate/secure-region addresses.
package oc8051_su_gate_pkg;

    typedef enum logic [1:0] {
        SU_FLT_NONE    = 2'd0,
        SU_FLT_ILLEGAL = 2'd1,
        SU_FLT_UNBAL   = 2'd2,
        SU_FLT_OVF     = 2'd3
    } su_fault_e;

    typedef enum logic [1:0] {
        SU_BOOT  = 2'd0,
        SU_USER  = 2'd1,
        SU_SUPER = 2'd2
    } su_state_e;

    typedef enum logic [2:0] {
        STK_NOP  = 3'd0,
        STK_PUSH = 3'd1,
        STK_POP  = 3'd2,
        STK_INCR = 3'd3,
        STK_DECR = 3'd4
    } stk_op_e;

    localparam logic [15:0] SU_GATE_ADDR = 16'h0100;
    localparam logic [15:0] SU_SEC_LO    = 16'h0100;
    localparam logic [15:0] SU_SEC_HI    = 16'h0FFF;

endpackage

// File: rtl/oc8051_su_frame_stack.sv
// Stack of supervisor frames, each holding a call-depth counter; index 0 may
// be the boot frame until it is popped, after which it never returns.
module oc8051_su_frame_stack
    import oc8051_su_gate_pkg::*;
#(
    parameter int NEST_DEPTH = 4,
    parameter int CALL_W     = 6,
    localparam int LVL_W     = $clog2(NEST_DEPTH + 1),
    localparam int IDX_W     = (NEST_DEPTH > 1) ? $clog2(NEST_DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  stk_op_e           i_op,
    output logic [CALL_W-1:0] o_top_depth,
    output logic              o_top_is_boot,
    output logic              o_boot_live,
    output logic              o_full,
    output logic              o_empty,
    output logic [LVL_W-1:0]  o_lvl
);

    logic [CALL_W-1:0] r_depth [NEST_DEPTH];
    logic [LVL_W-1:0]  r_lvl;
    logic              r_boot_mark;
    logic [IDX_W-1:0]  w_top_idx;
    logic [IDX_W-1:0]  w_push_idx;

    assign w_top_idx     = IDX_W'(r_lvl - LVL_W'(1));
    assign w_push_idx    = IDX_W'(r_lvl);
    assign o_empty       = (r_lvl == '0);
    assign o_full        = (r_lvl == LVL_W'(NEST_DEPTH));
    assign o_top_depth   = o_empty ? '0 : r_depth[w_top_idx];
    assign o_top_is_boot = r_boot_mark && (r_lvl == LVL_W'(1));
    assign o_boot_live   = r_boot_mark;
    assign o_lvl         = r_lvl;

    // NOTE: the frame array is a handful of flops, so it is reset like any
    // other state; a RAM macro would not allow this and is not wanted here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NEST_DEPTH; i++) r_depth[i] <= '0;
            r_lvl       <= LVL_W'(1);
            r_boot_mark <= 1'b1;
        end else begin
            unique case (i_op)
                STK_PUSH: if (!o_full) begin
                    r_depth[w_push_idx] <= '0;
                    r_lvl               <= r_lvl + LVL_W'(1);
                end
                STK_POP: if (!o_empty) begin
                    r_lvl <= r_lvl - LVL_W'(1);
                    if (r_lvl == LVL_W'(1)) r_boot_mark <= 1'b0;
                end
                STK_INCR: if (!o_empty && o_top_depth != '1)
                    r_depth[w_top_idx] <= o_top_depth + CALL_W'(1);
                STK_DECR: if (!o_empty && o_top_depth != '0)
                    r_depth[w_top_idx] <= o_top_depth - CALL_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/oc8051_su_gate.sv
// Watches committed calls/returns and emits registered enter/leave pulses to
// the privilege-level tracker, flagging illegal entry, imbalance and overflow.
module oc8051_su_gate
    import oc8051_su_gate_pkg::*;
#(
    parameter logic [15:0] GATE_ADDR  = SU_GATE_ADDR,
    parameter logic [15:0] SEC_LO     = SU_SEC_LO,
    parameter logic [15:0] SEC_HI     = SU_SEC_HI,
    parameter int          NEST_DEPTH = 4,
    parameter int          CALL_W     = 6,
    localparam int         LVL_W      = $clog2(NEST_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmt_valid,
    input  logic             cmt_call,
    input  logic             cmt_ret,
    input  logic [15:0]      cmt_target,
    input  logic             boot_done,
    input  logic             fault_clr,
    output logic             enter_su_mode,
    output logic             leave_su_mode,
    output logic [LVL_W-1:0] nest_lvl,
    output logic             su_fault,
    output logic [1:0]       fault_code
);

    su_state_e         r_state, w_state_nxt;
    logic              r_enter, r_leave, r_su_fault;
    su_fault_e         r_fault_code, w_code;
    logic              w_enter, w_leave, w_fault;
    stk_op_e           w_op;
    logic [CALL_W-1:0] w_top_depth;
    logic              w_top_is_boot, w_boot_live, w_full, w_empty;
    logic [LVL_W-1:0]  w_lvl;
    logic              w_gate, w_secure;

    assign w_gate   = (cmt_target == GATE_ADDR);
    assign w_secure = (cmt_target >= SEC_LO) && (cmt_target <= SEC_HI);

    oc8051_su_frame_stack #(
        .NEST_DEPTH (NEST_DEPTH),
        .CALL_W     (CALL_W)
    ) u_stack (
        .clk           (clk),
        .rst           (rst),
        .i_op          (w_op),
        .o_top_depth   (w_top_depth),
        .o_top_is_boot (w_top_is_boot),
        .o_boot_live   (w_boot_live),
        .o_full        (w_full),
        .o_empty       (w_empty),
        .o_lvl         (w_lvl)
    );

    // NOTE: every signal gets its default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        w_op        = STK_NOP;
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_leave     = 1'b0;
        w_fault     = 1'b0;
        w_code      = SU_FLT_NONE;

        if (cmt_valid) begin
            if (cmt_call && cmt_ret) begin
                w_fault = 1'b1;
                w_code  = SU_FLT_UNBAL;
            end else if (cmt_call) begin
                if (w_gate) begin
                    if (!w_full) begin
                        w_op        = STK_PUSH;
                        w_enter     = 1'b1;
                        w_state_nxt = SU_SUPER;
                    end else begin
                        w_fault = 1'b1;
                        w_code  = SU_FLT_OVF;
                    end
                end else if (r_state == SU_USER) begin
                    if (w_secure) begin
                        w_fault = 1'b1;
                        w_code  = SU_FLT_ILLEGAL;
                    end
                end else if (w_top_depth == '1) begin
                    w_fault = 1'b1;
                    w_code  = SU_FLT_OVF;
                end else begin
                    w_op = STK_INCR;
                end
            end else if (cmt_ret && r_state != SU_USER && !w_empty) begin
                if (w_top_depth != '0) begin
                    w_op = STK_DECR;
                end else if (w_top_is_boot) begin
                    w_fault = 1'b1;
                    w_code  = SU_FLT_UNBAL;
                end else begin
                    w_op    = STK_POP;
                    w_leave = 1'b1;
                    if (w_lvl == LVL_W'(1))
                        w_state_nxt = SU_USER;
                    else if (w_lvl == LVL_W'(2) && w_boot_live)
                        w_state_nxt = SU_BOOT;
                    else
                        w_state_nxt = SU_SUPER;
                end
            end
        end

        // A commit in the same cycle takes the slot; boot_done is then an error.
        if (boot_done) begin
            if (!cmt_valid && r_state == SU_BOOT && w_top_is_boot && w_top_depth == '0) begin
                w_op        = STK_POP;
                w_leave     = 1'b1;
                w_state_nxt = SU_USER;
            end else begin
                if (!w_fault) w_code = SU_FLT_UNBAL;
                w_fault = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= SU_BOOT;
            r_enter      <= 1'b0;
            r_leave      <= 1'b0;
            r_su_fault   <= 1'b0;
            r_fault_code <= SU_FLT_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_enter <= w_enter;
            r_leave <= w_leave;
            if (w_fault) begin
                r_su_fault <= 1'b1;
                if (!r_su_fault || fault_clr) r_fault_code <= w_code;
            end else if (fault_clr) begin
                r_su_fault   <= 1'b0;
                r_fault_code <= SU_FLT_NONE;
            end
        end
    end

    assign enter_su_mode = r_enter;
    assign leave_su_mode = r_leave;
    assign nest_lvl      = w_lvl;
    assign su_fault      = r_su_fault;
    assign fault_code    = r_fault_code;

endmodule

// File: tb/tb_oc8051_su_gate.sv
// Scoreboard bench for oc8051_su_gate: each driven cycle queues its expected
// outputs, which are popped and compared one clock later.
module tb_oc8051_su_gate;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmt_valid = 1'b0, cmt_call = 1'b0, cmt_ret = 1'b0;
    logic [15:0] cmt_target = 16'h0000;
    logic        boot_done = 1'b0, fault_clr = 1'b0;
    logic        enter_su_mode, leave_su_mode, su_fault;
    logic [2:0]  nest_lvl;
    logic [1:0]  fault_code;

    typedef struct {
        logic       enter;
        logic       leave;
        logic [2:0] lvl;
        logic       fault;
        logic [1:0] code;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;

    oc8051_su_gate dut (
        .clk           (clk),
        .rst           (rst),
        .cmt_valid     (cmt_valid),
        .cmt_call      (cmt_call),
        .cmt_ret       (cmt_ret),
        .cmt_target    (cmt_target),
        .boot_done     (boot_done),
        .fault_clr     (fault_clr),
        .enter_su_mode (enter_su_mode),
        .leave_su_mode (leave_su_mode),
        .nest_lvl      (nest_lvl),
        .su_fault      (su_fault),
        .fault_code    (fault_code)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t ex(input logic e, input logic l, input logic [2:0] lvl,
                                input logic f, input logic [1:0] c);
        exp_t r;
        r.enter = e; r.leave = l; r.lvl = lvl; r.fault = f; r.code = c;
        return r;
    endfunction

    task automatic compare_out(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check({tag, "/sb_empty"}, 16'd0, 16'd1);
            return;
        end
        e = sb_q.pop_front();
        check({tag, "/enter"}, 16'(enter_su_mode), 16'(e.enter));
        check({tag, "/leave"}, 16'(leave_su_mode), 16'(e.leave));
        check({tag, "/lvl"},   16'(nest_lvl),      16'(e.lvl));
        check({tag, "/fault"}, 16'(su_fault),      16'(e.fault));
        check({tag, "/code"},  16'(fault_code),    16'(e.code));
    endtask

    task automatic cyc(input string tag, input logic v, input logic c, input logic r,
                       input logic [15:0] tgt, input logic bd, input logic clr, input exp_t e);
        @(negedge clk);
        cmt_valid = v; cmt_call = c; cmt_ret = r; cmt_target = tgt;
        boot_done = bd; fault_clr = clr;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    task automatic call_to(input string tag, input logic [15:0] tgt, input exp_t e);
        cyc(tag, 1'b1, 1'b1, 1'b0, tgt, 1'b0, 1'b0, e);
    endtask

    task automatic ret_(input string tag, input exp_t e);
        cyc(tag, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, e);
    endtask

    task automatic idle(input string tag, input exp_t e);
        cyc(tag, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, e);
    endtask

    task automatic bootd(input string tag, input exp_t e);
        cyc(tag, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, e);
    endtask

    task automatic clr(input string tag, input exp_t e);
        cyc(tag, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, e);
    endtask

    task automatic check_now(input string tag, input exp_t e);
        sb_q.push_back(e);
        compare_out(tag);
    endtask

    task automatic apply_reset(input string tag);
        @(negedge clk);
        cmt_valid = 0; cmt_call = 0; cmt_ret = 0; boot_done = 0; fault_clr = 0;
        #2 rst = 1'b0;
        #1 check_now(tag, ex(0, 0, 1, 0, 0));
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #1 rst = 1'b0;
        #1 check_now("por", ex(0, 0, 1, 0, 0));
        @(negedge clk);
        rst = 1'b1;

        // Boot hand-off with no calls.
        idle ("boot_idle", ex(0, 0, 1, 0, 0));
        bootd("boot_done", ex(0, 1, 0, 0, 0));
        idle ("boot_post", ex(0, 0, 0, 0, 0));

        // Gate call with an inner call, balanced returns.
        call_to("gate_call",  16'h0100, ex(1, 0, 1, 0, 0));
        call_to("inner_call", 16'h0200, ex(0, 0, 1, 0, 0));
        ret_   ("inner_ret",            ex(0, 0, 1, 0, 0));
        ret_   ("gate_ret",             ex(0, 1, 0, 0, 0));
        ret_   ("user_ret",             ex(0, 0, 0, 0, 0));

        // Secure-region entry checks from USER.
        call_to("illegal_0300", 16'h0300, ex(0, 0, 0, 1, 1));
        clr    ("clr1",                   ex(0, 0, 0, 0, 0));
        call_to("illegal_0fff", 16'h0FFF, ex(0, 0, 0, 1, 1));
        clr    ("clr2",                   ex(0, 0, 0, 0, 0));
        call_to("user_1000",    16'h1000, ex(0, 0, 0, 0, 0));
        call_to("user_00ff",    16'h00FF, ex(0, 0, 0, 0, 0));

        // Nest to the limit, overflow, unwind.
        for (int i = 1; i <= 4; i++)
            call_to($sformatf("nest%0d", i), 16'h0100, ex(1, 0, 3'(i), 0, 0));
        call_to("nest_ovf", 16'h0100, ex(0, 0, 4, 1, 3));
        for (int i = 3; i >= 0; i--)
            ret_($sformatf("unwind%0d", i), ex(0, 1, 3'(i), 1, 3));
        call_to("sticky_code", 16'h0300, ex(0, 0, 0, 1, 3));
        cyc("clr_vs_fault", 1'b1, 1'b1, 1'b0, 16'h0300, 1'b0, 1'b1, ex(0, 0, 0, 1, 1));
        clr    ("clr3",          ex(0, 0, 0, 0, 0));
        bootd  ("boot_in_user",  ex(0, 0, 0, 1, 2));
        clr    ("clr4",          ex(0, 0, 0, 0, 0));

        // BOOT-frame imbalance and malformed commits.
        apply_reset("rst2");
        ret_   ("boot_ret0",  ex(0, 0, 1, 1, 2));
        clr    ("clr5",       ex(0, 0, 1, 0, 0));
        cyc("call_and_ret", 1'b1, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, ex(0, 0, 1, 1, 2));
        clr    ("clr6",       ex(0, 0, 1, 0, 0));
        call_to("boot_inner", 16'h0200, ex(0, 0, 1, 0, 0));
        bootd  ("boot_deep",  ex(0, 0, 1, 1, 2));
        clr    ("clr7",       ex(0, 0, 1, 0, 0));
        ret_   ("boot_inret", ex(0, 0, 1, 0, 0));
        call_to("boot_gate",  16'h0100, ex(1, 0, 2, 0, 0));
        ret_   ("back_boot",  ex(0, 1, 1, 0, 0));
        cyc("bd_with_cmt", 1'b1, 1'b1, 1'b0, 16'h0200, 1'b1, 1'b0, ex(0, 0, 1, 1, 2));
        clr    ("clr8",       ex(0, 0, 1, 0, 0));
        ret_   ("bd_cmt_ret", ex(0, 0, 1, 0, 0));
        bootd  ("boot_done2", ex(0, 1, 0, 0, 0));

        // Call-depth saturation in the boot frame.
        apply_reset("rst3");
        for (int i = 1; i <= 63; i++)
            call_to("sat_call", 16'h0200, ex(0, 0, 1, 0, 0));
        call_to("sat_ovf", 16'h0200, ex(0, 0, 1, 1, 3));
        clr    ("clr9",    ex(0, 0, 1, 0, 0));
        for (int i = 1; i <= 63; i++)
            ret_("sat_ret", ex(0, 0, 1, 0, 0));
        ret_   ("sat_under", ex(0, 0, 1, 1, 2));
        clr    ("clr10",     ex(0, 0, 1, 0, 0));

        // Asynchronous reset mid-SUPER with an enter pulse on the outputs.
        apply_reset("rst4");
        bootd("g_boot", ex(0, 1, 0, 0, 0));
        for (int i = 1; i <= 3; i++)
            call_to($sformatf("g_nest%0d", i), 16'h0100, ex(1, 0, 3'(i), 0, 0));
        #1 rst = 1'b0;
        cmt_valid = 0; cmt_call = 0;
        #1 check_now("async_rst", ex(0, 0, 1, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        idle ("post_rst",   ex(0, 0, 1, 0, 0));
        bootd("post_rst_bd", ex(0, 1, 0, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oc8051_su_gate.md
Name: oc8051_su_gate

Overview:
- Producer side of the privilege-level enter/leave interface: watches committed control-transfer instructions and issues single-cycle enter_su_mode / leave_su_mode pulses to the privilege-level tracker.
- Supervisor mode is entered only by a call to the gate address. It is left only by the RET that balances that call, or by boot_done for the boot frame.
- Flags illegal entry into the secure region, unbalanced returns and overflow.

Parameters:
- GATE_ADDR, 16'h0100, only legal call target for entering supervisor mode
- SEC_LO, 16'h0100, lowest address of the secure code region
- SEC_HI, 16'h0FFF, highest address of the secure code region
- NEST_DEPTH, 4, maximum nested supervisor frames, boot frame included
- CALL_W, 6, width of the per-frame call-depth counter

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- cmt_valid  in  1  one instruction committed this cycle
- cmt_call  in  1  committed instruction is LCALL/ACALL
- cmt_ret  in  1  committed instruction is RET/RETI
- cmt_target  in  16  call target PC; valid with cmt_call
- boot_done  in  1  boot firmware hands off to user code
- fault_clr  in  1  clears su_fault and fault_code
- enter_su_mode  out  1  one-cycle pulse; tracker increments
- leave_su_mode  out  1  one-cycle pulse; tracker decrements
- nest_lvl  out  $clog2(NEST_DEPTH+1)  number of active supervisor frames
- su_fault  out  1  sticky fault flag
- fault_code  out  2  0 none, 1 illegal entry, 2 unbalanced/ill-formed, 3 overflow

Behaviour:
- Reset (rst low, asynchronous):
  - state=BOOT, nest_lvl=1, frame[0] is the boot frame with depth 0.
  - enter_su_mode=0, leave_su_mode=0, su_fault=0, fault_code=0.
  - This matches the tracker's reset level of 1. Reset mid-sequence discards all frames.
- Events are sampled only when cmt_valid=1. All outputs are registered, so a pulse appears the cycle after the commit. There is never more than one pulse per cycle.
- States: BOOT (only the boot frame is active), USER (nest_lvl=0), SUPER (at least one gate frame).
- Call, in any state:
  - If cmt_target==GATE_ADDR and nest_lvl<NEST_DEPTH: push a new frame with depth 0, nest_lvl+1, pulse enter_su_mode, state=SUPER.
  - If cmt_target==GATE_ADDR and nest_lvl==NEST_DEPTH: fault 3, no push, no pulse.
- Call in USER with target in [SEC_LO,SEC_HI] and not GATE_ADDR: fault 1, no pulse.
- Call in BOOT/SUPER that is not a gate call: top-frame depth+1. At depth all-ones: fault 3, depth saturates.
- RET in USER: ignored, no fault (user-level returns).
- RET in BOOT or SUPER:
  - If top-frame depth>0: depth-1.
  - If top-frame depth==0 and top frame is a gate frame: pop, nest_lvl-1, pulse leave_su_mode. When nest_lvl reaches 0, state=USER. When only the boot frame remains, state=BOOT.
  - If top-frame depth==0 and top frame is the boot frame: fault 2, no pop.
- boot_done:
  - In BOOT with depth 0: pop the boot frame, nest_lvl=0, pulse leave_su_mode, state=USER.
  - boot_done anywhere else: fault 2, ignored.
  - The boot frame can never be re-created except by reset.
- cmt_call and cmt_ret both high: fault 2, no state change.
- boot_done and cmt_valid in the same cycle: the commit is processed first; boot_done is treated as an error (fault 2).
- Faults:
  - The first fault latches fault_code. Later faults keep su_fault=1 without overwriting the code.
  - fault_clr clears both next cycle. A fault in the same cycle as fault_clr wins.
- The frame stack is NEST_DEPTH x CALL_W registers plus a boot-frame marker bit for index 0. It is indexed by nest_lvl-1 and needs no memory macro.

Decomposition:
- Shared package (oc8051_defines.v additions): fault code constants SU_FLT_NONE/ILLEGAL/UNBAL/OVF, state encodings SU_BOOT/SU_USER/SU_SUPER, default gate and region addresses.
- One sub-module, oc8051_su_frame_stack: push, pop, incr, decr on the top-of-stack counter; outputs top_depth, top_is_boot, full, empty.
- The FSM, fault logic and pulse generation stay in oc8051_su_gate.

Test Plan:
- Reset, then boot_done with no calls -> next cycle leave_su_mode=1 for exactly one cycle, nest_lvl=0, state USER, su_fault=0.
- From USER:
  - Stimulus: call 16'h0100, then an inner call to 16'h0200, then RET, RET.
  - Required: enter pulse one cycle after the first call; no pulse on the inner call or first RET; leave pulse after the second RET; nest_lvl 0→1→0.
- From USER, call 16'h0300 -> su_fault=1, fault_code=1, no enter pulse, nest_lvl=0; fault_clr -> su_fault=0 next cycle.
- Nest 4 gate calls from USER: four enter pulses and nest_lvl=4. A 5th gate call gives fault_code=3, no pulse, nest_lvl stays 4. Four RETs give four leave pulses.
- RET in BOOT at depth 0 -> fault_code=2, nest_lvl stays 1, no leave pulse. cmt_call and cmt_ret together -> fault flagged, state unchanged.
- Assert rst low asynchronously mid-SUPER (nest_lvl=3, a pulse pending) -> outputs clear immediately, nest_lvl=1, state BOOT, no pulse after release.
